// File: rtl/lrb_pkg.sv
// Shared definitions for the load register bank: shadow-op mode encodings.
package lrb_pkg;

  typedef enum logic [1:0] {
    MODE_LOAD  = 2'b00,
    MODE_INC   = 2'b01,
    MODE_DEC   = 2'b10,
    MODE_CLEAR = 2'b11
  } lrb_mode_t;

endpackage

// File: rtl/load_register_bank_if.sv
// Control/status bundle between a front panel (buttons, LCD driver) and the register bank.
interface load_register_bank_if #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned CHANNELS = 4
);
  localparam int unsigned SEL_W = $clog2(CHANNELS);

  logic [WIDTH-1:0]          din;
  logic [SEL_W-1:0]          sel;
  logic [1:0]                mode;
  logic                      load;
  logic                      commit;
  logic [CHANNELS*WIDTH-1:0] q;
  logic                      upd_valid;
  logic [SEL_W-1:0]          upd_sel;
  logic                      sel_err;
  logic                      commit_done;

  modport master (
    output din, sel, mode, load, commit,
    input  q, upd_valid, upd_sel, sel_err, commit_done
  );

  modport slave (
    input  din, sel, mode, load, commit,
    output q, upd_valid, upd_sel, sel_err, commit_done
  );
endinterface

// File: rtl/load_register_bank_rise_detect.sv
// One-cycle strobe on a rising level. The previous-sample register resets to 1 so a
// level already high when reset releases does not count as an edge.
module rise_detect (
  input  logic clk,
  input  logic rst,
  input  logic sig,
  output logic rise
);
  logic prev_q;

  // Track last sampled level; synchronous active-low reset to 1.
  always_ff @(posedge clk) begin
    if (!rst) prev_q <= 1'b1;
    else      prev_q <= sig;
  end

  // Strobe is high only in the first cycle the level is seen high.
  always_comb begin
    rise = sig & ~prev_q;
  end
endmodule

// File: rtl/load_register_bank.sv
// Double-buffered register bank: edge-triggered ops edit a shadow bank, and a commit edge
// copies every shadow to the active bank in one cycle so multi-digit displays never tear.
module load_register_bank
  import lrb_pkg::*;
#(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned CHANNELS = 4
) (
  input logic                 clk,
  input logic                 rst,
  load_register_bank_if.slave bus
);
  localparam int unsigned SEL_W = $clog2(CHANNELS);

  logic [WIDTH-1:0] shadow_q [CHANNELS];
  logic [WIDTH-1:0] shadow_d [CHANNELS];
  logic [WIDTH-1:0] active_q [CHANNELS];

  logic             ld_edge;
  logic             cm_edge;
  logic             sel_ok;
  logic             op_ok;
  lrb_mode_t        mode;

  logic             upd_valid_q;
  logic [SEL_W-1:0] upd_sel_q;
  logic             sel_err_q;
  logic             commit_done_q;

  rise_detect u_load_edge (
    .clk  (clk),
    .rst  (rst),
    .sig  (bus.load),
    .rise (ld_edge)
  );

  rise_detect u_commit_edge (
    .clk  (clk),
    .rst  (rst),
    .sig  (bus.commit),
    .rise (cm_edge)
  );

  // Qualify the op request: sel may exceed CHANNELS when CHANNELS is not a power of 2.
  always_comb begin
    mode   = lrb_mode_t'(bus.mode);
    sel_ok = (32'(bus.sel) < 32'(CHANNELS));
    op_ok  = ld_edge & sel_ok;
  end

  // Next shadow state: only the selected channel moves; arithmetic wraps naturally.
  always_comb begin
    shadow_d = shadow_q;
    for (int k = 0; k < CHANNELS; k++) begin
      if (op_ok && (bus.sel == SEL_W'(k))) begin
        unique case (mode)
          MODE_LOAD:  shadow_d[k] = bus.din;
          MODE_INC:   shadow_d[k] = shadow_q[k] + WIDTH'(1);
          MODE_DEC:   shadow_d[k] = shadow_q[k] - WIDTH'(1);
          MODE_CLEAR: shadow_d[k] = '0;
        endcase
      end
    end
  end

  // Bank state; commit copies pre-op shadow values, so a same-cycle op lands in shadow only.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int k = 0; k < CHANNELS; k++) begin
        shadow_q[k] <= '0;
        active_q[k] <= '0;
      end
    end else begin
      shadow_q <= shadow_d;
      if (cm_edge) active_q <= shadow_q;
    end
  end

  // Registered status pulses; upd_sel holds between ops.
  always_ff @(posedge clk) begin
    if (!rst) begin
      upd_valid_q   <= 1'b0;
      upd_sel_q     <= '0;
      sel_err_q     <= 1'b0;
      commit_done_q <= 1'b0;
    end else begin
      upd_valid_q   <= op_ok;
      sel_err_q     <= ld_edge & ~sel_ok;
      commit_done_q <= cm_edge;
      if (op_ok) upd_sel_q <= bus.sel;
    end
  end

  // Flatten the active bank onto q, channel k at bits [k*WIDTH +: WIDTH].
  always_comb begin
    bus.q = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      bus.q[k*WIDTH +: WIDTH] = active_q[k];
    end
    bus.upd_valid   = upd_valid_q;
    bus.upd_sel     = upd_sel_q;
    bus.sel_err     = sel_err_q;
    bus.commit_done = commit_done_q;
  end
endmodule

// File: tb/tb_load_register_bank.sv
// Directed bench: a 4-channel and a 3-channel bank share one stimulus stream.
module tb_load_register_bank;
  import lrb_pkg::*;

  logic       clk;
  logic       rst;
  logic [3:0] din;
  logic [1:0] sel;
  logic [1:0] mode;
  logic       load;
  logic       commit;

  int n_checks;
  int n_fail;

  logic       uv4, se4, cd4, uv3, se3, cd3;
  logic [1:0] us4;
  int         extra;

  load_register_bank_if #(.WIDTH(4), .CHANNELS(4)) b4 ();
  load_register_bank_if #(.WIDTH(4), .CHANNELS(3)) b3 ();

  assign b4.din = din;
  assign b4.sel = sel;
  assign b4.mode = mode;
  assign b4.load = load;
  assign b4.commit = commit;
  assign b3.din = din;
  assign b3.sel = sel;
  assign b3.mode = mode;
  assign b3.load = load;
  assign b3.commit = commit;

  load_register_bank #(.WIDTH(4), .CHANNELS(4)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (b4)
  );

  load_register_bank #(.WIDTH(4), .CHANNELS(3)) dut3 (
    .clk (clk),
    .rst (rst),
    .bus (b3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One op edge; captures the status seen in the cycle after the edge.
  task automatic op(input lrb_mode_t m, input logic [1:0] s, input logic [3:0] d);
    mode = m;
    sel  = s;
    din  = d;
    load = 1'b1;
    tick();
    uv4 = b4.upd_valid;
    us4 = b4.upd_sel;
    se4 = b4.sel_err;
    uv3 = b3.upd_valid;
    se3 = b3.sel_err;
    load = 1'b0;
    tick();
  endtask

  task automatic do_commit();
    commit = 1'b1;
    tick();
    cd4 = b4.commit_done;
    cd3 = b3.commit_done;
    commit = 1'b0;
    tick();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b0;
    din = '0;
    sel = '0;
    mode = MODE_LOAD;
    load = 1'b1;
    commit = 1'b0;

    // Reset with load held high across release.
    repeat (3) tick();
    check("rst_q4", 32'(b4.q), 32'h0);
    check("rst_q3", 32'(b3.q), 32'h0);
    check("rst_upd_valid", 32'(b4.upd_valid), 32'h0);
    check("rst_upd_sel", 32'(b4.upd_sel), 32'h0);
    check("rst_sel_err", 32'(b4.sel_err), 32'h0);
    check("rst_commit_done", 32'(b4.commit_done), 32'h0);
    rst = 1'b1;
    tick();
    check("held_load_no_fire0", 32'(b4.upd_valid), 32'h0);
    tick();
    check("held_load_no_fire1", 32'(b4.upd_valid), 32'h0);
    check("held_load_q", 32'(b4.q), 32'h0);
    load = 1'b0;
    tick();

    // LOAD 0xA on ch2 with the button held for 5 cycles.
    mode = MODE_LOAD;
    sel  = 2'd2;
    din  = 4'hA;
    load = 1'b1;
    tick();
    check("load_upd_valid", 32'(b4.upd_valid), 32'h1);
    check("load_upd_sel", 32'(b4.upd_sel), 32'h2);
    extra = 0;
    repeat (4) begin
      tick();
      if (b4.upd_valid) extra++;
    end
    check("held_single_pulse", 32'(extra), 32'h0);
    check("load_upd_sel_hold", 32'(b4.upd_sel), 32'h2);
    check("load_q_unchanged", 32'(b4.q), 32'h0);
    load = 1'b0;
    tick();
    do_commit();
    check("commit_done", 32'(cd4), 32'h1);
    check("commit_q", 32'(b4.q), 32'h0A00);
    check("commit_done_clear", 32'(b4.commit_done), 32'h0);

    // Wrap cases plus CLEAR of ch2.
    op(MODE_LOAD, 2'd0, 4'hF);
    op(MODE_INC, 2'd0, 4'h0);
    op(MODE_DEC, 2'd1, 4'h0);
    check("dec_upd_sel", 32'(us4), 32'h1);
    op(MODE_CLEAR, 2'd2, 4'h0);
    check("pre_commit_q", 32'(b4.q), 32'h0A00);
    do_commit();
    check("wrap_q", 32'(b4.q), 32'h00F0);

    // Simultaneous op and commit edges.
    op(MODE_LOAD, 2'd0, 4'h5);
    mode   = MODE_INC;
    sel    = 2'd0;
    load   = 1'b1;
    commit = 1'b1;
    tick();
    check("sim_commit_done", 32'(b4.commit_done), 32'h1);
    check("sim_upd_valid", 32'(b4.upd_valid), 32'h1);
    check("sim_q_preop", 32'(b4.q), 32'h00F5);
    load   = 1'b0;
    commit = 1'b0;
    tick();
    do_commit();
    check("sim_next_commit_q", 32'(b4.q), 32'h00F6);

    // Reset mid-sequence discards uncommitted shadow edits.
    op(MODE_LOAD, 2'd3, 4'h7);
    op(MODE_INC, 2'd1, 4'h0);
    rst = 1'b0;
    tick();
    check("midrst_q4", 32'(b4.q), 32'h0);
    check("midrst_q3", 32'(b3.q), 32'h0);
    rst = 1'b1;
    tick();
    do_commit();
    check("midrst_commit_done", 32'(cd4), 32'h1);
    check("midrst_commit_q", 32'(b4.q), 32'h0);

    // Out-of-range select on the 3-channel bank.
    op(MODE_LOAD, 2'd2, 4'h9);
    do_commit();
    check("c3_commit_done", 32'(cd3), 32'h1);
    check("c3_q", 32'(b3.q), 32'h900);
    check("c4_q", 32'(b4.q), 32'h0900);
    op(MODE_INC, 2'd3, 4'h0);
    check("c3_sel_err", 32'(se3), 32'h1);
    check("c3_no_upd", 32'(uv3), 32'h0);
    check("c4_upd_valid", 32'(uv4), 32'h1);
    check("c4_upd_sel", 32'(us4), 32'h3);
    check("c4_no_sel_err", 32'(se4), 32'h0);
    check("c3_sel_err_pulse", 32'(b3.sel_err), 32'h0);
    do_commit();
    check("c3_shadow_unchanged", 32'(b3.q), 32'h900);
    check("c4_ch3_inc", 32'(b4.q), 32'h1900);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/load_register_bank.md
Name: load_register_bank

Overview:
- Parametrised successor of the single 4-bit load register.
- Holds CHANNELS independent WIDTH-bit registers in a double-buffered shadow/active pair.
- Ops on the shadow bank are edge-triggered from button or control inputs: load, increment, decrement, clear.
- A commit edge copies all shadows to the active outputs atomically, so the LCD driver never sees a half-updated multi-digit value.

Parameters:
- WIDTH, 4, bit width of each channel register.
- CHANNELS, 4, number of channels (>=2; need not be a power of 2).
- SEL_W, $clog2(CHANNELS), derived localparam width of sel; not overridable.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  reset, synchronous, active-low.
- din  input  WIDTH  data for LOAD op.
- sel  input  SEL_W  target shadow channel.
- mode  input  2  op select: 00 LOAD, 01 INC, 10 DEC, 11 CLEAR.
- load  input  1  op request, level (button or control); acts on rising edge only.
- commit  input  1  commit request, level; acts on rising edge only.
- q  output  CHANNELS*WIDTH  active bank, channel k at bits [k*WIDTH +: WIDTH].
- upd_valid  output  1  one-cycle pulse after a shadow op is performed.
- upd_sel  output  SEL_W  channel of the last performed op.
- sel_err  output  1  one-cycle pulse when an op edge had sel >= CHANNELS.
- commit_done  output  1  one-cycle pulse after a commit.

Behaviour:
- Reset (rst==0 at posedge):
  - all shadow and active registers = 0, so q = 0.
  - upd_valid = sel_err = commit_done = 0; upd_sel = 0.
  - load_prev = commit_prev = 1, so a button held through reset release does not fire.
  - Reset has priority over every other input.
- Edge detect:
  - ld_edge = load & ~load_prev; cm_edge = commit & ~commit_prev.
  - prev registers sample the inputs every cycle.
  - A level held high for N cycles produces exactly one action.
- Op at posedge P where ld_edge=1 and sel<CHANNELS, on shadow[sel]:
  - LOAD: shadow <= din.
  - INC: shadow <= shadow+1, modulo 2^WIDTH (all-ones wraps to 0).
  - DEC: shadow <= shadow-1, modulo 2^WIDTH (0 wraps to all-ones).
  - CLEAR: shadow <= 0.
  - Other channels are unchanged.
  - upd_valid = 1 and upd_sel = sel during the cycle after P; upd_valid = 0 otherwise. upd_sel holds its value between ops.
- Out-of-range op (ld_edge=1, sel>=CHANNELS):
  - No shadow change, upd_valid stays 0.
  - sel_err = 1 for the cycle after P.
- Commit at posedge P where cm_edge=1:
  - active[k] <= shadow[k] for all k, using the shadow values before any same-cycle op.
  - commit_done = 1 for the cycle after P.
  - q changes only on commit or reset.
- Simultaneous ld_edge and cm_edge:
  - Both take effect at the same posedge.
  - Active receives the pre-op shadow; the op lands in shadow only and appears in q at the next commit.
- Latency:
  - Shadow op: 1 cycle from the sampled edge.
  - Commit: q valid 1 cycle after the sampled edge.
  - No back-pressure; a new edge can be accepted every other cycle (edge requires a low sample in between).
- Reset mid-sequence: pending shadow changes are discarded; q returns to 0.

Decomposition:
- Shared package lrb_pkg holds:
  - mode encodings MODE_LOAD=2'b00, MODE_INC=2'b01, MODE_DEC=2'b10, MODE_CLEAR=2'b11.
  - typedef lrb_mode_t.
- Sub-module rise_detect (1-bit, synchronous active-low reset to 1):
  - one instance each for load and commit.
  - output is the one-cycle edge strobe.
- Shadow/active arrays stay inline in load_register_bank.

Test Plan:
- Reset behaviour: hold rst=0 with load=1, then release, keeping load=1 -> no upd_valid; q=0 remains.
- LOAD then commit: WIDTH=4, CHANNELS=4; LOAD din=4'hA sel=2, hold load 5 cycles -> shadow[2]=A once, single upd_valid with upd_sel=2, q unchanged. Then commit edge -> q=16'h0A00, commit_done pulse.
- Wrap: LOAD 4'hF on ch0, INC -> 0. DEC on ch1 from 0 -> 4'hF. Commit -> q=16'h00F0.
- Out-of-range: CHANNELS=3, SEL_W=2, op edge with sel=3 -> sel_err pulse, no upd_valid, all shadows unchanged.
- Simultaneous edges: shadow[0]=5, assert load (INC ch0) and commit on the same cycle -> q ch0=5, shadow[0]=6. Next commit -> q ch0=6.
- Reset mid-sequence: after shadow ops without commit, pulse rst=0 -> q=0, and a following commit yields q=0.
